// File: rtl/sb_pkg.sv
// Shared definitions for the store buffer.
// Holds the default depth, the address/data widths and the buffered-entry
// record used by the top level and the forwarding matcher.
package sb_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;

  // One buffered store. Stores are word-aligned, so only the word address is kept.
  typedef struct packed {
    logic                valid;
    logic [ADDR_W-1:2]   addr;
    logic [DATA_W-1:0]   data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Load-forwarding query bus of the store buffer.
//   ld_valid : load request
//   ld_addr  : load byte address
//   ld_hit   : load matches a buffered store
//   ld_data  : forwarded store data (0 when no hit)
// master = the side issuing the load query, slave = the side answering it.
interface store_buffer_if;
  import sb_pkg::*;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;

  modport master (output ld_valid, ld_addr, input  ld_hit, ld_data);
  modport slave  (input  ld_valid, ld_addr, output ld_hit, ld_data);

endinterface

// File: rtl/store_buffer_fwd.sv
// Youngest-match store-to-load forwarding.
// Ports:
//   entries : snapshot of all buffer slots (registered state only)
//   tail    : next write slot; tail-1 is the youngest entry
//   ld      : load query bus (slave side)
// Purely combinational.
module store_buffer_fwd
  import sb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  sb_entry_t                  entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   tail,
  store_buffer_if.slave              ld
);

  localparam int PTR_W = $clog2(DEPTH);

  logic              hit_any;
  logic [DATA_W-1:0] sel_data;
  logic [PTR_W-1:0]  idx;
  logic              unused_ld_lsb;

  // Byte offset within the word does not take part in the match.
  assign unused_ld_lsb = ^ld.ld_addr[1:0];

  // Walk from the oldest slot (tail-DEPTH == tail) to the youngest (tail-1);
  // a later match overrides an earlier one, so the youngest store wins.
  always_comb begin
    hit_any  = 1'b0;
    sel_data = '0;
    idx      = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PTR_W'(k);
      if (entries[idx].valid && (entries[idx].addr == ld.ld_addr[ADDR_W-1:2])) begin
        hit_any  = 1'b1;
        sel_data = entries[idx].data;
      end
    end
  end

  assign ld.ld_hit  = ld.ld_valid && hit_any;
  assign ld.ld_data = (ld.ld_valid && hit_any) ? sel_data : '0;

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer: a circular FIFO of pending stores that drains to
// data memory in order and forwards the youngest matching store to loads.
// Ports:
//   clk_i, rst_i               : clock, synchronous active-high reset
//   st_valid_i/addr_i/data_i   : store request from EX/MEM
//   st_ready_o                 : store accepted this cycle (not full)
//   ld_valid_i/addr_i          : load query
//   ld_hit_o/ld_data_o         : forwarding result
//   mem_req_o/addr_o/data_o    : head-entry drain request to data memory
//   mem_ack_i                  : memory accepted the head write
//   empty_o/full_o/count_o     : occupancy status
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     st_valid_i,
  input  logic [ADDR_W-1:0]        st_addr_i,
  input  logic [DATA_W-1:0]        st_data_i,
  output logic                     st_ready_o,
  input  logic                     ld_valid_i,
  input  logic [ADDR_W-1:0]        ld_addr_i,
  output logic                     ld_hit_o,
  output logic [DATA_W-1:0]        ld_data_o,
  output logic                     mem_req_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_data_o,
  input  logic                     mem_ack_i,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Control state (reset)
  logic [DEPTH-1:0] vld_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  // Payload storage (not reset; always qualified by vld_q / empty)
  logic [ADDR_W-1:2] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic      empty;
  logic      full;
  logic      push;
  logic      pop;
  logic      unused_st_lsb;
  sb_entry_t entries [DEPTH];

  assign unused_st_lsb = ^st_addr_i[1:0];

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // No bypass when full: a pop on the same edge does not free a slot for the
  // incoming store, so push and pop can only coincide when neither full nor
  // empty, i.e. on distinct slots.
  assign push = st_valid_i && !full;
  assign pop  = !empty && mem_ack_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[tail_q] <= st_addr_i[ADDR_W-1:2];
      data_q[tail_q] <= st_data_i;
    end
  end

  // Forwarding sees only registered entries: a store written on this edge
  // appears next cycle, and an entry popped on this edge is still visible now.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = '{valid: vld_q[i], addr: addr_q[i], data: data_q[i]};
    end
  end

  store_buffer_if ld_bus ();

  assign ld_bus.ld_valid = ld_valid_i;
  assign ld_bus.ld_addr  = ld_addr_i;
  assign ld_hit_o        = ld_bus.ld_hit;
  assign ld_data_o       = ld_bus.ld_data;

  store_buffer_fwd #(.DEPTH(DEPTH)) u_fwd (
    .entries (entries),
    .tail    (tail_q),
    .ld      (ld_bus.slave)
  );

  assign st_ready_o = !full;
  assign mem_req_o  = !empty;
  assign mem_addr_o = empty ? '0 : {addr_q[head_q], 2'b00};
  assign mem_data_o = empty ? '0 : data_q[head_q];
  assign empty_o    = empty;
  assign full_o     = full;
  assign count_o    = count_q;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic        empty;
  logic        full;
  logic [2:0]  count;

  store_buffer_if ldb ();

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .st_valid_i (st_valid),
    .st_addr_i  (st_addr),
    .st_data_i  (st_data),
    .st_ready_o (st_ready),
    .ld_valid_i (ldb.ld_valid),
    .ld_addr_i  (ldb.ld_addr),
    .ld_hit_o   (ldb.ld_hit),
    .ld_data_o  (ldb.ld_data),
    .mem_req_o  (mem_req),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_data),
    .mem_ack_i  (mem_ack),
    .empty_o    (empty),
    .full_o     (full),
    .count_o    (count)
  );

  typedef struct {
    logic        st_v;
    logic [31:0] st_a;
    logic [31:0] st_d;
    logic        ld_v;
    logic [31:0] ld_a;
    logic        ack;
    logic        e_rdy;
    logic        e_hit;
    logic [31:0] e_ld;
    logic        e_req;
    logic [31:0] e_ma;
    logic [31:0] e_md;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                              input logic lv, input logic [31:0] la, input logic ak,
                              input logic rdy, input logic hit, input logic [31:0] ld,
                              input logic req, input logic [31:0] ma, input logic [31:0] md,
                              input logic [2:0] cnt);
    vec_t v;
    v.st_v = sv; v.st_a = sa; v.st_d = sd; v.ld_v = lv; v.ld_a = la; v.ack = ak;
    v.e_rdy = rdy; v.e_hit = hit; v.e_ld = ld; v.e_req = req; v.e_ma = ma; v.e_md = md;
    v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la, input logic ak);
    st_valid = sv; st_addr = sa; st_data = sd;
    ldb.ld_valid = lv; ldb.ld_addr = la; mem_ack = ak;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic rdy, input logic hit, input logic [31:0] ld,
                         input logic req, input logic [31:0] ma, input logic [31:0] md,
                         input logic [2:0] cnt);
    chk({nm, ".st_ready"}, {31'd0, st_ready}, {31'd0, rdy});
    chk({nm, ".ld_hit"},   {31'd0, ldb.ld_hit}, {31'd0, hit});
    chk({nm, ".ld_data"},  ldb.ld_data, ld);
    chk({nm, ".mem_req"},  {31'd0, mem_req}, {31'd0, req});
    chk({nm, ".mem_addr"}, mem_addr, ma);
    chk({nm, ".mem_data"}, mem_data, md);
    chk({nm, ".count"},    {29'd0, count}, {29'd0, cnt});
    chk({nm, ".empty"},    {31'd0, empty}, {31'd0, (cnt == 3'd0)});
    chk({nm, ".full"},     {31'd0, full},  {31'd0, (cnt == 3'd4)});
  endtask

  initial begin
    //           st_v st_a     st_d          ld_v ld_a   ack rdy hit ld_data       req ma     md            cnt
    tbl[0]  = mk(0, 32'h00, 32'h0,          0, 32'h00, 0,  1, 0, 32'h0,          0, 32'h00, 32'h0,          3'd0);
    tbl[1]  = mk(1, 32'h10, 32'hAAAA0001,   1, 32'h10, 0,  1, 0, 32'h0,          0, 32'h00, 32'h0,          3'd0);
    tbl[2]  = mk(0, 32'h00, 32'h0,          1, 32'h10, 0,  1, 1, 32'hAAAA0001,   1, 32'h10, 32'hAAAA0001,   3'd1);
    tbl[3]  = mk(1, 32'h20, 32'h1,          0, 32'h00, 0,  1, 0, 32'h0,          1, 32'h10, 32'hAAAA0001,   3'd1);
    tbl[4]  = mk(1, 32'h20, 32'h2,          0, 32'h00, 0,  1, 0, 32'h0,          1, 32'h10, 32'hAAAA0001,   3'd2);
    tbl[5]  = mk(0, 32'h00, 32'h0,          1, 32'h22, 0,  1, 1, 32'h2,          1, 32'h10, 32'hAAAA0001,   3'd3);
    tbl[6]  = mk(0, 32'h00, 32'h0,          1, 32'h24, 0,  1, 0, 32'h0,          1, 32'h10, 32'hAAAA0001,   3'd3);
    tbl[7]  = mk(1, 32'h30, 32'h3,          0, 32'h00, 0,  1, 0, 32'h0,          1, 32'h10, 32'hAAAA0001,   3'd3);
    tbl[8]  = mk(1, 32'h40, 32'h4,          1, 32'h20, 0,  0, 1, 32'h2,          1, 32'h10, 32'hAAAA0001,   3'd4);
    tbl[9]  = mk(1, 32'h40, 32'h4,          0, 32'h00, 1,  0, 0, 32'h0,          1, 32'h10, 32'hAAAA0001,   3'd4);
    tbl[10] = mk(1, 32'h40, 32'h4,          1, 32'h10, 0,  1, 0, 32'h0,          1, 32'h20, 32'h1,          3'd3);
    tbl[11] = mk(0, 32'h00, 32'h0,          1, 32'h40, 0,  0, 1, 32'h4,          1, 32'h20, 32'h1,          3'd4);
    tbl[12] = mk(0, 32'h00, 32'h0,          1, 32'h20, 1,  0, 1, 32'h2,          1, 32'h20, 32'h1,          3'd4);
    tbl[13] = mk(0, 32'h00, 32'h0,          1, 32'h20, 1,  1, 1, 32'h2,          1, 32'h20, 32'h2,          3'd3);
    tbl[14] = mk(1, 32'h50, 32'h5,          0, 32'h00, 1,  1, 0, 32'h0,          1, 32'h30, 32'h3,          3'd2);
    tbl[15] = mk(1, 32'h60, 32'h6,          0, 32'h00, 1,  1, 0, 32'h0,          1, 32'h40, 32'h4,          3'd2);
    tbl[16] = mk(0, 32'h00, 32'h0,          0, 32'h00, 1,  1, 0, 32'h0,          1, 32'h50, 32'h5,          3'd2);
    tbl[17] = mk(0, 32'h00, 32'h0,          1, 32'h60, 1,  1, 1, 32'h6,          1, 32'h60, 32'h6,          3'd1);
    tbl[18] = mk(0, 32'h00, 32'h0,          1, 32'h60, 1,  1, 0, 32'h0,          0, 32'h00, 32'h0,          3'd0);
    tbl[19] = mk(0, 32'h00, 32'h0,          0, 32'h00, 0,  1, 0, 32'h0,          0, 32'h00, 32'h0,          3'd0);

    rst = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 32'h0, 0);
    repeat (2) tick();
    rst = 1'b0;

    // Directed table: outputs are checked with the inputs applied, before the edge.
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].st_v, tbl[i].st_a, tbl[i].st_d, tbl[i].ld_v, tbl[i].ld_a, tbl[i].ack);
      #3;
      chk_all($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_hit, tbl[i].e_ld, tbl[i].e_req,
              tbl[i].e_ma, tbl[i].e_md, tbl[i].e_cnt);
      tick();
    end

    // Nine stores with steady-state push+pop at count 2; drain order across wrap.
    drive(1, 32'h100, 32'hD0000000, 0, 32'h0, 0);
    #3; chk("wrap.count_s0", {29'd0, count}, 32'd0);
    tick();
    drive(1, 32'h104, 32'hD0000001, 0, 32'h0, 0);
    #3; chk("wrap.count_s1", {29'd0, count}, 32'd1);
    tick();
    for (int k = 2; k <= 8; k++) begin
      drive(1, 32'h100 + 32'(4 * k), 32'hD0000000 + 32'(k), 0, 32'h0, 1);
      #3;
      chk($sformatf("wrap.count_k%0d", k), {29'd0, count}, 32'd2);
      chk($sformatf("wrap.addr_k%0d", k), mem_addr, 32'h100 + 32'(4 * (k - 2)));
      chk($sformatf("wrap.data_k%0d", k), mem_data, 32'hD0000000 + 32'(k - 2));
      tick();
    end
    for (int j = 7; j <= 8; j++) begin
      drive(0, 32'h0, 32'h0, 0, 32'h0, 1);
      #3;
      chk($sformatf("drain.count_j%0d", j), {29'd0, count}, 32'(9 - j));
      chk($sformatf("drain.addr_j%0d", j), mem_addr, 32'h100 + 32'(4 * j));
      chk($sformatf("drain.data_j%0d", j), mem_data, 32'hD0000000 + 32'(j));
      tick();
    end
    drive(0, 32'h0, 32'h0, 0, 32'h0, 0);
    #3; chk_all("drained", 1, 0, 32'h0, 0, 32'h0, 32'h0, 3'd0);
    tick();

    // Reset with three pending stores, a store and an ack on the same edge.
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h200 + 32'(4 * k), 32'hE0000000 + 32'(k), 0, 32'h0, 0);
      tick();
    end
    rst = 1'b1;
    drive(1, 32'h20C, 32'hE0000003, 0, 32'h0, 1);
    #3; chk("rst.pending", {29'd0, count}, 32'd3);
    tick();
    rst = 1'b0;
    drive(0, 32'h0, 32'h0, 1, 32'h200, 0);
    #3; chk_all("rst.after", 1, 0, 32'h0, 0, 32'h0, 32'h0, 3'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 32'h0, 32'h0, 1, 32'h20C, 0);
      #3;
      chk($sformatf("rst.idle_req%0d", k), {31'd0, mem_req}, 32'd0);
      chk($sformatf("rst.idle_hit%0d", k), {31'd0, ldb.ld_hit}, 32'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
